sdram_cmd_sched: RTL and testbench

Top-level command scheduler for the SDRAM controller. Shares the command bus between the sequence-generator FSMs: activate, burst read, burst write with auto-precharge, and auto-refresh. It decides which generator runs next and drives that generator's start/done handshake. It also owns the periodic refresh timer and muxes the active generator's 4-bit command onto the bus.

---
 rtl/sdram_cmd_sched.sv | 172 +++++++++++++++++
 tb/tb_sdram_cmd_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_sched.sv
// SDRAM command scheduler: arbitrates the activate, read, write and refresh
// sequence generators over one command bus and owns the periodic refresh timer.
module sdram_cmd_sched #(
    parameter int REF_PERIOD = 780,
    parameter int CW         = $clog2(REF_PERIOD)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_req,
    input  logic       wr_req,
    output logic       rd_ack,
    output logic       wr_ack,
    output logic       start_act,
    output logic       start_rd,
    output logic       start_wr,
    output logic       start_ref,
    input  logic       done_act,
    input  logic       done_rd,
    input  logic       done_wr,
    input  logic       done_ref,
    input  logic [3:0] cmd_act,
    input  logic [3:0] cmd_rd,
    input  logic [3:0] cmd_wr,
    input  logic [3:0] cmd_ref,
    output logic [3:0] command,
    output logic       busy,
    output logic       ref_overflow
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACT, S_ACT_REL, S_RD, S_WR, S_REF, S_REL
    } state_t;

    typedef enum logic [1:0] {OWN_RD, OWN_WR, OWN_REF} owner_t;

    localparam logic          OP_RD      = 1'b0;
    localparam logic          OP_WR      = 1'b1;
    localparam logic [CW-1:0] REF_RELOAD = CW'(REF_PERIOD - 1);

    state_t        r_state;
    state_t        w_next_state;
    owner_t        r_owner;
    logic          r_op;
    logic          r_last_op;
    logic          w_grant;
    logic          w_grant_op;
    logic [CW-1:0] r_ref_cnt;
    logic          r_ref_pending;
    logic          r_ref_overflow;
    logic          w_ref_expire;
    logic          w_ref_clear;
    logic          w_owner_done;
    logic [3:0]    w_command;

    assign w_ref_expire = (r_ref_cnt == '0);
    assign w_ref_clear  = (r_state == S_REF) && done_ref;

    // An expiry that lands on the clearing cycle re-arms the request instead
    // of counting as an overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_cnt      <= REF_RELOAD;
            r_ref_pending  <= 1'b0;
            r_ref_overflow <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_ref_cnt <= w_ref_expire ? REF_RELOAD : r_ref_cnt - CW'(1);
            if (w_ref_expire) begin
                r_ref_pending <= 1'b1;
                if (r_ref_pending && !w_ref_clear) begin
                    r_ref_overflow <= 1'b1;
                end
            end else if (w_ref_clear) begin
                r_ref_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_owner_done = 1'b0;
        case (r_owner)
            OWN_RD:  w_owner_done = done_rd;
            OWN_WR:  w_owner_done = done_wr;
            OWN_REF: w_owner_done = done_ref;
            default: w_owner_done = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_op   = r_op;
        case (r_state)
            S_IDLE: begin
                if (r_ref_pending) begin
                    w_next_state = S_REF;
                end else if (rd_req || wr_req) begin
                    w_grant      = 1'b1;
                    w_next_state = S_ACT;
                    if (rd_req && wr_req) begin
                        w_grant_op = (r_last_op == OP_WR) ? OP_RD : OP_WR;
                    end else begin
                        w_grant_op = rd_req ? OP_RD : OP_WR;
                    end
                end
            end
            S_ACT:     if (done_act) w_next_state = S_ACT_REL;
            S_ACT_REL: if (!done_act) w_next_state = (r_op == OP_RD) ? S_RD : S_WR;
            S_RD:      if (done_rd) w_next_state = S_REL;
            S_WR:      if (done_wr) w_next_state = S_REL;
            S_REF:     if (done_ref) w_next_state = S_REL;
            S_REL:     if (!w_owner_done) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // The owner is tracked while a generator runs so REL knows whose done to
    // wait on and whose command to keep on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= OP_RD;
            r_last_op <= OP_WR;
            r_owner   <= OWN_RD;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_op      <= w_grant_op;
                r_last_op <= w_grant_op;
            end
            case (r_state)
                S_RD:    r_owner <= OWN_RD;
                S_WR:    r_owner <= OWN_WR;
                S_REF:   r_owner <= OWN_REF;
                default: r_owner <= r_owner;
            endcase
        end
    end

    always_comb begin
        w_command = 4'h0;
        case (r_state)
            S_ACT, S_ACT_REL: w_command = cmd_act;
            S_RD:             w_command = cmd_rd;
            S_WR:             w_command = cmd_wr;
            S_REF:            w_command = cmd_ref;
            S_REL: begin
                case (r_owner)
                    OWN_RD:  w_command = cmd_rd;
                    OWN_WR:  w_command = cmd_wr;
                    OWN_REF: w_command = cmd_ref;
                    default: w_command = 4'h0;
                endcase
            end
            default:          w_command = 4'h0;
        endcase
    end

    assign start_act    = (r_state == S_ACT);
    assign start_rd     = (r_state == S_RD);
    assign start_wr     = (r_state == S_WR);
    assign start_ref    = (r_state == S_REF);
    assign rd_ack       = (r_state == S_RD) && done_rd;
    assign wr_ack       = (r_state == S_WR) && done_wr;
    assign busy         = (r_state != S_IDLE);
    assign command      = w_command;
    assign ref_overflow = r_ref_overflow;

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Scoreboard bench for sdram_cmd_sched: directed request patterns, a generator
// responder model, and a negedge monitor that checks grant order and acks.
module tb_sdram_cmd_sched;

    localparam int         REF_PERIOD = 20;
    localparam logic [3:0] CMD_ACT    = 4'hA;
    localparam logic [3:0] CMD_RD     = 4'h5;
    localparam logic [3:0] CMD_WR     = 4'hC;
    localparam logic [3:0] CMD_REF    = 4'h1;

    typedef enum logic [1:0] {G_RD, G_WR, G_REF} grant_e;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd_req = 1'b0;
    logic       wr_req = 1'b0;
    logic       rd_ack, wr_ack;
    logic       start_act, start_rd, start_wr, start_ref;
    logic       done_act = 1'b0;
    logic       done_rd  = 1'b0;
    logic       done_wr  = 1'b0;
    logic       done_ref = 1'b0;
    logic [3:0] command;
    logic       busy, ref_overflow;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     n_rd_ack = 0;
    int     n_wr_ack = 0;
    grant_e exp_q[$];

    int   lat = 1;
    logic ref_hold = 1'b0;
    int   cnt_act = 0, cnt_rd = 0, cnt_wr = 0, cnt_ref = 0;
    logic p_act = 1'b0, p_rd = 1'b0, p_wr = 1'b0, p_ref = 1'b0;
    logic p_rd_ack = 1'b0, p_wr_ack = 1'b0;

    sdram_cmd_sched #(.REF_PERIOD(REF_PERIOD)) u_dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req),
        .rd_ack(rd_ack), .wr_ack(wr_ack),
        .start_act(start_act), .start_rd(start_rd), .start_wr(start_wr), .start_ref(start_ref),
        .done_act(done_act), .done_rd(done_rd), .done_wr(done_wr), .done_ref(done_ref),
        .cmd_act(CMD_ACT), .cmd_rd(CMD_RD), .cmd_wr(CMD_WR), .cmd_ref(CMD_REF),
        .command(command), .busy(busy), .ref_overflow(ref_overflow)
    );

    always #5 clk = ~clk;

    // Generator responders: done rises lat cycles after start, falls the cycle after start drops.
    always @(posedge clk) begin
        if (!start_act) begin cnt_act <= 0; done_act <= 1'b0; end
        else if (cnt_act >= lat - 1) done_act <= 1'b1;
        else cnt_act <= cnt_act + 1;
    end
    always @(posedge clk) begin
        if (!start_rd) begin cnt_rd <= 0; done_rd <= 1'b0; end
        else if (cnt_rd >= lat - 1) done_rd <= 1'b1;
        else cnt_rd <= cnt_rd + 1;
    end
    always @(posedge clk) begin
        if (!start_wr) begin cnt_wr <= 0; done_wr <= 1'b0; end
        else if (cnt_wr >= lat - 1) done_wr <= 1'b1;
        else cnt_wr <= cnt_wr + 1;
    end
    always @(posedge clk) begin
        if (!start_ref) begin cnt_ref <= 0; done_ref <= 1'b0; end
        else if (cnt_ref >= lat - 1) begin
            if (!ref_hold) done_ref <= 1'b1;
        end
        else cnt_ref <= cnt_ref + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_grant(input grant_e g);
        grant_e e;
        check("sb_grant_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_grant_order", g, e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if ((start_act && !p_act) || (start_rd && !p_rd) ||
                (start_wr && !p_wr) || (start_ref && !p_ref))
                check("start_while_done_high", {done_act, done_rd, done_wr, done_ref}, 4'b0);
            if (start_rd && !p_rd)   sb_grant(G_RD);
            if (start_wr && !p_wr)   sb_grant(G_WR);
            if (start_ref && !p_ref) sb_grant(G_REF);
            if (rd_ack) begin
                n_rd_ack <= n_rd_ack + 1;
                check("rd_ack_single_pulse", p_rd_ack, 1'b0);
            end
            if (wr_ack) begin
                n_wr_ack <= n_wr_ack + 1;
                check("wr_ack_single_pulse", p_wr_ack, 1'b0);
            end
        end
        p_act    <= start_act;
        p_rd     <= start_rd;
        p_wr     <= start_wr;
        p_ref    <= start_ref;
        p_rd_ack <= rd_ack;
        p_wr_ack <= wr_ack;
    end

    task automatic do_reset();
        rst    = 1'b1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, exp_q.size(), 0);
        check({name, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int base_rd, base_wr;
        logic rel_next;

        // Reset state, with both requests asserted.
        rd_req = 1'b1;
        wr_req = 1'b1;
        #3;
        check("rst_starts", {start_act, start_rd, start_wr, start_ref}, 4'b0);
        check("rst_acks", {rd_ack, wr_ack}, 2'b0);
        check("rst_command", command, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", ref_overflow, 1'b0);

        // Single read, generators take 6 cycles; refresh follows at the first expiry.
        do_reset();
        lat = 6;
        base_rd = n_rd_ack;
        exp_q.push_back(G_RD);
        exp_q.push_back(G_REF);
        rd_req = 1'b1;
        @(posedge clk); #1;
        check("t2_act_latency", start_act, 1'b1);
        check("t2_cmd_act", command, CMD_ACT);
        check("t2_busy", busy, 1'b1);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!start_rd && k < 30);
        check("t2_rd_start_cycle", k, 9);
        check("t2_cmd_rd", command, CMD_RD);
        k = 0;
        rel_next = 1'b0;
        do begin
            @(posedge clk); #1; k++;
            if (rel_next) begin
                check("t2_cmd_rel", command, CMD_RD);
                rel_next = 1'b0;
            end
            if (rd_ack) begin
                rd_req   = 1'b0;
                rel_next = 1'b1;
            end
        end while (busy && k < 30);
        check("t2_idle_cycle", k, 9);
        check("t2_cmd_idle", command, 4'h0);
        check("t2_rd_acks", n_rd_ack - base_rd, 1);
        wait_drained("t2_drained", 60);

        // Tied requests: RD, WR, RD, then the pending refresh.
        do_reset();
        lat = 1;
        base_rd = n_rd_ack;
        base_wr = n_wr_ack;
        exp_q.push_back(G_RD);
        exp_q.push_back(G_WR);
        exp_q.push_back(G_RD);
        exp_q.push_back(G_REF);
        rd_req = 1'b1;
        wr_req = 1'b1;
        k = 0;
        while ((n_rd_ack - base_rd) + (n_wr_ack - base_wr) < 3 && k < 80) begin
            @(negedge clk); k++;
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        wait_drained("t3_drained", 60);
        check("t3_rd_acks", n_rd_ack - base_rd, 2);
        check("t3_wr_acks", n_wr_ack - base_wr, 1);

        // Continuous writes: refresh slots in after the write in flight at expiry.
        do_reset();
        lat = 1;
        base_wr = n_wr_ack;
        exp_q.push_back(G_WR);
        exp_q.push_back(G_WR);
        exp_q.push_back(G_WR);
        exp_q.push_back(G_REF);
        exp_q.push_back(G_WR);
        exp_q.push_back(G_REF);
        wr_req = 1'b1;
        k = 0;
        while (!done_ref && k < 80) begin @(negedge clk); k++; end
        check("t4_done_ref_seen", done_ref, 1'b1);
        check("t4_pending_before", u_dut.r_ref_pending, 1'b1);
        check("t4_writes_before_ref", n_wr_ack - base_wr, 3);
        @(negedge clk);
        check("t4_pending_cleared", u_dut.r_ref_pending, 1'b0);
        k = 0;
        while (n_wr_ack - base_wr < 4 && k < 80) begin @(negedge clk); k++; end
        wr_req = 1'b0;
        wait_drained("t4_drained", 60);
        check("t4_wr_acks", n_wr_ack - base_wr, 4);

        // Reset in the middle of a write, then timer restart.
        do_reset();
        lat = 6;
        exp_q.push_back(G_WR);
        wr_req = 1'b1;
        k = 0;
        while (!start_wr && k < 40) begin @(negedge clk); k++; end
        check("t5_in_write", start_wr, 1'b1);
        #2;
        rst    = 1'b1;
        wr_req = 1'b0;
        #1;
        check("t5_starts", {start_act, start_rd, start_wr, start_ref}, 4'b0);
        check("t5_command", command, 4'h0);
        check("t5_busy", busy, 1'b0);
        check("t5_sb_empty", exp_q.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(G_REF);
        k = 0;
        do begin @(posedge clk); #1; k++; end
        while (!u_dut.r_ref_pending && k < 100);
        check("t5_first_refresh", k, REF_PERIOD);
        wait_drained("t5_drained", 60);

        // Refresh never completes: second expiry sets a sticky overflow.
        do_reset();
        lat = 1;
        ref_hold = 1'b1;
        exp_q.push_back(G_REF);
        repeat (39) @(posedge clk);
        #1;
        check("t6_overflow_early", ref_overflow, 1'b0);
        check("t6_pending", u_dut.r_ref_pending, 1'b1);
        @(posedge clk); #1;
        check("t6_overflow_set", ref_overflow, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("t6_overflow_sticky", ref_overflow, 1'b1);
        check("t6_ref_stuck", start_ref, 1'b1);
        check("t6_sb_empty", exp_q.size(), 0);
        rst = 1'b1;
        #1;
        check("t6_overflow_rst", ref_overflow, 1'b0);
        ref_hold = 1'b0;

        // Expiry coincides with done_ref: pending survives, no overflow, refresh repeats.
        do_reset();
        lat = 1;
        ref_hold = 1'b1;
        exp_q.push_back(G_REF);
        exp_q.push_back(G_REF);
        repeat (38) @(posedge clk);
        @(negedge clk);
        ref_hold = 1'b0;
        @(posedge clk); #1;
        check("t7_done_ref", done_ref, 1'b1);
        check("t7_overflow_before", ref_overflow, 1'b0);
        @(posedge clk); #1;
        check("t7_pending_kept", u_dut.r_ref_pending, 1'b1);
        check("t7_overflow_clear", ref_overflow, 1'b0);
        check("t7_in_rel", {start_ref, busy}, 2'b01);
        check("t7_cmd_rel", command, CMD_REF);
        wait_drained("t7_drained", 40);
        check("t7_pending_final", u_dut.r_ref_pending, 1'b0);
        check("t7_overflow_final", ref_overflow, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
